fix2float_sched: RTL and testbench
==================================

# fix2float_sched

Sequencer and round-robin arbiter that shares one fixed-to-floating-point converter between two fixed-point requesters in the Expanded Hyperbolic CORDIC output path. It drives the select of the external 2:1 32-bit operand mux, pulses the converter start, supervises completion with a timeout, and returns each float result tagged with its requester through a valid/ready port.

## Interface
- `W`, 32: data width of operands and results.
- `TIMEOUT`, 64: maximum cycles in WAIT before abort; minimum 2.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0_valid`, `req1_valid` in 1: requester has an operand on its mux input (D_0 / D_1), held stable until its ready.
- `req0_ready`, `req1_ready` out 1: one-cycle completion strobe; requester may drop or change its operand after it.
- `ms` out 1: operand mux select; 0 = requester 0, 1 = requester 1.
- `conv_start` out 1: one-cycle start pulse to converter.
- `conv_done` in 1: converter result valid, one-cycle pulse.
- `conv_result` in W: converter float output, sampled on `conv_done`.
- `res_valid` out 1: result available.
- `res_ready` in 1: downstream accepts result.
- `res_data` out W: float result.
- `res_tag` out 1: requester index of `res_data`.
- `res_err` out 1: result produced by timeout abort.

## Operation
- States: IDLE, START, WAIT, RESP.
- IDLE: if neither valid, stay. If exactly one valid, grant it. If both valid, grant the requester that is not `last` (`last` = tag of the most recently completed transaction; reset value 1, so requester 0 wins first). Register grant into `ms` and `res_tag`; go START.
- START: `conv_start`=1 for this cycle only; clear timer; go WAIT. `conv_done` in START is ignored.
- WAIT: timer increments each cycle. On `conv_done`: capture `conv_result` into `res_data`, `res_err`=0, go RESP. Else if timer == TIMEOUT-1: `res_data`=32'h7FC0_0000 (quiet NaN), `res_err`=1, go RESP. `conv_done` takes priority when both occur in the same cycle.
- RESP: `res_valid`=1; `res_data`, `res_tag`, `res_err` held stable. On `res_valid && res_ready`: assert `req<res_tag>_ready` combinationally in that cycle, update `last`=`res_tag`, go IDLE.
- `ms` is held at the current grant from IDLE exit until the next grant; it never changes in START, WAIT or RESP.
- Requester dropping valid mid-transaction is a protocol violation; the transaction still completes and the ready strobe is still issued.
- New requests are never accepted outside IDLE; one transaction is in flight at a time.

## Timing
- Reset, asynchronous: state=IDLE, `ms`=0, `last`=1, timer=0, `conv_start`=0, `res_valid`=0, `res_data`=0, `res_tag`=0, `res_err`=0. Both ready outputs are 0. Reset mid-transaction discards it; pending requesters are re-arbitrated after reset release.
- Cycle 0: IDLE samples valid. Cycle 1: START, `ms` settled, `conv_start` high. `conv_done` at cycle k≥2 gives `res_valid` at k+1.
- With `res_ready` held high, requester ready fires at k+1, IDLE at k+2, and the next `conv_start` at k+3.
- Timeout: with no `conv_done`, `res_valid` rises TIMEOUT cycles after the `conv_start` cycle.
- All outputs are registered except `req*_ready`, which is state and `res_ready` gated.

## Structure
- Shared package `fix2float_pkg`: state enum, `FP_QNAN32` = 32'h7FC0_0000, default `TIMEOUT`, and tag type.
- One sub-module, `rr_arb2`: combinational two-way round-robin grant from valids and `last`, outputting the grant index and an any-grant flag.
- The operand mux stays external; this block only drives its select.

## Test plan
- Reset, then only `req1_valid` with converter latency 3 -> `ms`=1 from cycle 1, `conv_start` at cycle 1, `res_valid` at cycle 5, `res_tag`=1, `req1_ready` pulsed on accept.
- Both valid continuously, with `res_ready`=1 -> grants alternate 0,1,0,1; `ms` is stable across each transaction.
- `res_ready` low for 10 cycles in RESP -> `res_data`, `res_tag` and `res_valid` are held unchanged; no `req_ready` until accept; no new `conv_start`.
- Converter never asserts done, `TIMEOUT`=8 -> `res_valid` 8 cycles after `conv_start`, `res_data`=32'h7FC00000, `res_err`=1; the next transaction shows `res_err`=0.
- `conv_done` on the same cycle as the timeout limit -> `conv_result` is captured and `res_err`=0. `conv_done` during START -> ignored.
- `rst_n` asserted in WAIT -> all outputs go to reset values immediately. After release with both valid -> requester 0 is granted.

Source files
------------

// File: rtl/fix2float_pkg.sv
// Shared types and constants for the fixed-to-float converter scheduler.
package fix2float_pkg;

  // Sequencer states: arbitrate, kick the converter, wait for it, hand off result.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Requester index carried alongside each result.
  typedef logic tag_t;

  // Result returned when the converter never answers.
  localparam logic [31:0] FP_QNAN32 = 32'h7FC0_0000;

  // Default converter supervision window in cycles.
  localparam int TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/fix2float_sched_rr_arb2.sv
// Two-way round-robin grant: the requester that did not win last time wins a tie.
module rr_arb2
  import fix2float_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic last,
  output logic grant,
  output logic any_grant
);

  // Pure combinational grant selection from the two valids and the previous winner.
  always_comb begin
    // NOTE: every output gets a value before any branch so no latch is inferred.
    grant     = 1'b0;
    any_grant = valid0 | valid1;
    if (valid0 && valid1) begin
      grant = ~last;
    end else if (valid1) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/fix2float_sched.sv
// Shares one fixed-to-float converter between two requesters: drives the
// operand mux select, pulses the converter start, supervises completion with a
// timeout and returns each tagged result through a valid/ready port.
module fix2float_sched
  import fix2float_pkg::*;
#(
  parameter int W       = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  output logic         ms,
  output logic         conv_start,
  input  logic         conv_done,
  input  logic [W-1:0] conv_result,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         res_tag,
  output logic         res_err
);

  // Wide enough to hold TIMEOUT itself, which the counter touches on exit.
  localparam int TW = $clog2(TIMEOUT) + 1;

  state_t        state;
  state_t        state_nxt;
  logic          last;
  logic [TW-1:0] timer;
  logic          grant;
  logic          any_req;
  logic          accept;
  logic          timeout_hit;

  rr_arb2 u_arb (
    .valid0    (req0_valid),
    .valid1    (req1_valid),
    .last      (last),
    .grant     (grant),
    .any_grant (any_req)
  );

  // The timer counts cycles elapsed since the conv_start cycle, so the last
  // WAIT cycle before abort is the one where it reads TIMEOUT-1.
  assign timeout_hit = (timer == TW'(TIMEOUT - 1));
  assign accept      = (state == ST_RESP) && res_valid && res_ready;

  // Completion strobes are the only unregistered outputs: the handshake cycle itself.
  assign req0_ready = accept && (res_tag == 1'b0);
  assign req1_ready = accept && (res_tag == 1'b1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; conv_done outside WAIT is ignored by construction.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (any_req) state_nxt = ST_START;
      ST_START: state_nxt = ST_WAIT;
      ST_WAIT:  if (conv_done || timeout_hit) state_nxt = ST_RESP;
      ST_RESP:  if (accept) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Registered outputs, grant bookkeeping and the supervision timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms         <= 1'b0;
      last       <= 1'b1;
      timer      <= '0;
      conv_start <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_tag    <= 1'b0;
      res_err    <= 1'b0;
    end else begin
      conv_start <= (state == ST_IDLE) && any_req;

      if (state == ST_START || state == ST_WAIT) begin
        timer <= timer + TW'(1);
      end else begin
        timer <= '0;
      end

      case (state)
        ST_IDLE: begin
          // Select and tag are latched together and then frozen until the next grant.
          if (any_req) begin
            ms      <= grant;
            res_tag <= grant;
          end
        end
        ST_WAIT: begin
          // A real result beats the abort when both land in the same cycle.
          if (conv_done) begin
            res_data  <= conv_result;
            res_err   <= 1'b0;
            res_valid <= 1'b1;
          end else if (timeout_hit) begin
            res_data  <= W'(FP_QNAN32);
            res_err   <= 1'b1;
            res_valid <= 1'b1;
          end
        end
        ST_RESP: begin
          if (accept) begin
            res_valid <= 1'b0;
            last      <= res_tag;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fix2float_sched.sv
// Self-checking bench for fix2float_sched: directed scenarios pinned with
// hand-computed cycle numbers, then randomized traffic against a
// transaction-level reference model checked every cycle.
module tb_fix2float_sched;

  localparam int          W    = 32;
  localparam int          TO   = 8;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic         clk         = 1'b0;
  logic         rst_n       = 1'b0;
  logic         req0_valid  = 1'b0;
  logic         req1_valid  = 1'b0;
  logic         conv_done   = 1'b0;
  logic         res_ready   = 1'b0;
  logic [W-1:0] conv_result = '0;
  logic         req0_ready;
  logic         req1_ready;
  logic         ms;
  logic         conv_start;
  logic         res_valid;
  logic [W-1:0] res_data;
  logic         res_tag;
  logic         res_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Converter behaviour knobs: latency 0 means it never answers.
  int          conv_lat    = 2;
  int          conv_cnt    = 0;
  int          stray_cyc   = -1;
  logic [31:0] last_result = '0;

  logic [1:0] rdy_seen = '0;
  int         acc_tags[$];

  // Reference model: one transaction in flight, described by when it started
  // and whether its result has been produced.
  bit          m_busy  = 1'b0;
  bit          m_have  = 1'b0;
  int          m_start = -10;
  logic        m_tag   = 1'b0;
  logic        m_last  = 1'b1;
  logic        m_grant = 1'b0;
  logic        m_err   = 1'b0;
  logic [31:0] m_data  = '0;

  fix2float_sched #(.W(W), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req1_valid  (req1_valid),
    .req0_ready  (req0_ready),
    .req1_ready  (req1_ready),
    .ms          (ms),
    .conv_start  (conv_start),
    .conv_done   (conv_done),
    .conv_result (conv_result),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_tag     (res_tag),
    .res_err     (res_err)
  );

  always #5 clk = ~clk;

  // Free-running cycle index shared by all processes.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fire();
    conv_done   = 1'b1;
    conv_result = $urandom;
    last_result = conv_result;
  endtask

  // Converter model: answers conv_lat cycles after the start cycle, plus optional stray pulses.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      conv_done = 1'b0;
      if (conv_cnt > 0) begin
        conv_cnt--;
        if (conv_cnt == 0) fire();
      end
      if (cyc == stray_cyc) fire();
    end
  end

  // Arm the converter model when it sees a start pulse.
  always @(negedge clk) begin
    if (!rst_n) conv_cnt = 0;
    else if (conv_start && conv_lat > 0) conv_cnt = conv_lat;
  end

  // Per-cycle comparison against the model, then advance the model with this cycle's inputs.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy  = 1'b0;
      m_have  = 1'b0;
      m_last  = 1'b1;
      m_grant = 1'b0;
      m_tag   = 1'b0;
      m_start = -10;
      check("rst_ms", ms, 0);
      check("rst_conv_start", conv_start, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_data", res_data, 0);
      check("rst_res_tag", res_tag, 0);
      check("rst_res_err", res_err, 0);
      check("rst_req0_ready", req0_ready, 0);
      check("rst_req1_ready", req1_ready, 0);
    end else begin
      check("ms", ms, m_grant);
      check("conv_start", conv_start, m_busy && !m_have && (cyc == m_start));
      check("res_valid", res_valid, m_have);
      check("res_tag", res_tag, m_tag);
      check("req0_ready", req0_ready, m_have && res_ready && !m_tag);
      check("req1_ready", req1_ready, m_have && res_ready && m_tag);
      if (m_have) begin
        check("res_data", res_data, m_data);
        check("res_err", res_err, m_err);
      end
      if (req0_ready) begin acc_tags.push_back(0); rdy_seen[0] = 1'b1; end
      if (req1_ready) begin acc_tags.push_back(1); rdy_seen[1] = 1'b1; end

      if (m_have) begin
        if (res_ready) begin
          m_last = m_tag;
          m_have = 1'b0;
          m_busy = 1'b0;
        end
      end else if (m_busy) begin
        if (cyc > m_start) begin
          if (conv_done) begin
            m_have = 1'b1; m_data = conv_result; m_err = 1'b0;
          end else if (cyc == m_start + TO - 1) begin
            m_have = 1'b1; m_data = QNAN; m_err = 1'b1;
          end
        end
      end else if (req0_valid || req1_valid) begin
        m_tag   = (req0_valid && req1_valid) ? ~m_last : req1_valid;
        m_grant = m_tag;
        m_busy  = 1'b1;
        m_start = cyc + 1;
      end
    end
  end

  // Wait (bounded) for conv_start (which=0) or res_valid (which=1); returns its cycle.
  task automatic wait_out(input int which, input string name, output int at);
    at = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if ((which == 0 && conv_start) || (which == 1 && res_valid)) begin
        at = cyc;
        break;
      end
    end
    check({name, "_seen"}, at >= 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int g, cs, rv;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single requester 1, latency 3: start at cycle 1, result at cycle 5.
    @(posedge clk); #1;
    conv_lat = 3; res_ready = 1'b1; req1_valid = 1'b1; g = cyc;
    wait_out(0, "t1_start", cs);
    check("t1_start_cycle", cs - g, 1);
    check("t1_ms", ms, 1);
    wait_out(1, "t1_valid", rv);
    check("t1_valid_cycle", rv - g, 5);
    check("t1_tag", res_tag, 1);
    check("t1_req1_ready", req1_ready, 1);
    check("t1_req0_ready", req0_ready, 0);
    @(posedge clk); #1 req1_valid = 1'b0;

    // Both valid continuously: grants alternate starting with requester 0.
    @(posedge clk); #1;
    acc_tags.delete();
    conv_lat = 2; req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 200 && acc_tags.size() < 4; k++) @(negedge clk);
    check("t2_count", acc_tags.size(), 4);
    if (acc_tags.size() >= 4) begin
      check("t2_grant0", acc_tags[0], 0);
      check("t2_grant1", acc_tags[1], 1);
      check("t2_grant2", acc_tags[2], 0);
      check("t2_grant3", acc_tags[3], 1);
    end
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;

    // Downstream stalls 10 cycles: result held, no strobe, no new start.
    @(posedge clk); #1;
    res_ready = 1'b0; conv_lat = 2; req0_valid = 1'b1;
    wait_out(1, "t3_valid", rv);
    repeat (10) begin
      @(negedge clk);
      check("t3_hold_valid", res_valid, 1);
      check("t3_hold_data", res_data, last_result);
      check("t3_hold_tag", res_tag, 0);
      check("t3_no_ready", req0_ready, 0);
      check("t3_no_start", conv_start, 0);
    end
    @(posedge clk); #1 res_ready = 1'b1;
    @(negedge clk);
    check("t3_ready_on_accept", req0_ready, 1);
    @(posedge clk); #1 req0_valid = 1'b0;

    // Converter never answers: abort 8 cycles after start with a quiet NaN.
    @(posedge clk); #1;
    conv_lat = 0; req1_valid = 1'b1;
    wait_out(0, "t4_start", cs);
    wait_out(1, "t4_valid", rv);
    check("t4_timeout_cycle", rv - cs, 8);
    check("t4_data", res_data, 32'h7FC0_0000);
    check("t4_err", res_err, 1);
    check("t4_tag", res_tag, 1);
    @(posedge clk); #1 conv_lat = 2;
    wait_out(1, "t4b_valid", rv);
    check("t4b_err", res_err, 0);
    check("t4b_data", res_data, last_result);
    @(posedge clk); #1 req1_valid = 1'b0;

    // Done on the timeout limit wins over the abort.
    @(posedge clk); #1;
    conv_lat = TO - 1; req0_valid = 1'b1;
    wait_out(0, "t5_start", cs);
    wait_out(1, "t5_valid", rv);
    check("t5_limit_cycle", rv - cs, 8);
    check("t5_limit_err", res_err, 0);
    check("t5_limit_data", res_data, last_result);

    // Done during START is ignored; the real answer follows 3 cycles later.
    @(posedge clk); #1;
    conv_lat = 3; stray_cyc = cyc + 1;
    wait_out(0, "t5s_start", cs);
    check("t5s_start_cycle", cs, stray_cyc);
    wait_out(1, "t5s_valid", rv);
    check("t5s_valid_cycle", rv - cs, 4);
    check("t5s_err", res_err, 0);
    check("t5s_data", res_data, last_result);
    @(posedge clk); #1 req0_valid = 1'b0;

    // Reset in WAIT: outputs clear at once; requester 0 wins first afterwards.
    @(posedge clk); #1;
    conv_lat = 0; req0_valid = 1'b1; req1_valid = 1'b1;
    wait_out(0, "t6_start", cs);
    check("t6_ms_before", ms, 1);
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("t6_rst_ms", ms, 0);
    check("t6_rst_valid", res_valid, 0);
    check("t6_rst_tag", res_tag, 0);
    check("t6_rst_start", conv_start, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; conv_lat = 2;
    wait_out(0, "t6_after_start", cs);
    check("t6_ms_after", ms, 0);

    // Randomized traffic; requesters hold valid until their strobe.
    rdy_seen = '0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      if (rdy_seen[0]) req0_valid = 1'($urandom_range(0, 1));
      else if (!req0_valid) req0_valid = ($urandom_range(0, 2) == 0);
      if (rdy_seen[1]) req1_valid = 1'($urandom_range(0, 1));
      else if (!req1_valid) req1_valid = ($urandom_range(0, 2) == 0);
      rdy_seen  = '0;
      res_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0:       conv_lat = 0;
        1:       conv_lat = TO - 1;
        2:       conv_lat = TO + 4;
        default: conv_lat = $urandom_range(1, 5);
      endcase
      if ($urandom_range(0, 15) == 0) stray_cyc = cyc + 1;
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
